// File: rtl/sm83_pkg.sv
// rtl/sm83_pkg.sv - shared types and constants for the SM83 sequencer
//
// Purpose: sequencer state encoding, bus word size and interrupt vector
// layout, plus a helper that maps a source index to its restart vector.
// Ports: none (package).
package sm83_pkg;

  localparam int WORD_SIZE = 8;
  localparam logic [WORD_SIZE-1:0] INT_VEC_BASE = 8'h40;
  localparam int INT_VEC_STEP = 8;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STOP = 2'd2,
    ST_INT  = 2'd3
  } seq_state_e;

  // Restart address of interrupt source idx: 0x40, 0x48, 0x50, ...
  function automatic logic [WORD_SIZE-1:0] irq_vector(input logic [WORD_SIZE-1:0] idx);
    return INT_VEC_BASE + idx * WORD_SIZE'(INT_VEC_STEP);
  endfunction

endpackage

// File: rtl/sm83_irq_prio.sv
// rtl/sm83_irq_prio.sv - fixed-priority interrupt encoder, bit 0 highest
//
// Purpose: pick the lowest-numbered pending request.
// Ports:
//   req_i     in   NUM_IRQ  pending requests (IE & IF)
//   onehot_o  out  NUM_IRQ  one-hot winner, all zero when nothing pending
//   idx_o     out  IDX_W    index of the winner, zero when nothing pending
//   valid_o   out  1        at least one request pending
module sm83_irq_prio #(
  parameter int NUM_IRQ = 5,
  parameter int IDX_W   = 3
) (
  input  logic [NUM_IRQ-1:0] req_i,
  output logic [NUM_IRQ-1:0] onehot_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  // Scan from the top down so the lowest set bit is the last writer.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
        idx_o       = IDX_W'(i);
        valid_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sm83_sequencer.sv
// rtl/sm83_sequencer.sv - SM83 M/T-cycle sequencer with HALT/STOP and interrupt dispatch
//
// Purpose: owns the opcode register, CB-bank flag, T/M counters, HALT/STOP
// states and the interrupt dispatch sequence.
// Optional feature: define SM83_HALT_BUG_EN to model the HALT bug (leaving
// HALT with ime=0 and a pending interrupt re-reads the next byte, pc_inc=0).
// Ports:
//   clk          in   1        core clock
//   reset_n      in   1        asynchronous active-low reset
//   ce           in   1        T-state enable
//   data_in      in   8        bus read data, valid at t_cycle==3
//   mcyc_last    in   1        current M-cycle is last of instruction
//   dec_halt     in   1        decoder: HALT
//   dec_stop     in   1        decoder: STOP
//   dec_prefix   in   1        decoder: CB prefix
//   ime          in   1        interrupt master enable
//   irq_pending  in   NUM_IRQ  IE & IF
//   wake         in   1        STOP exit
//   opcode       out  8        current opcode
//   bank_cb      out  1        opcode is CB-prefixed
//   in_halt      out  1        in HALT
//   in_alu       out  1        opcode is an ALU operation
//   t_cycle      out  2        T-state
//   m_cycle      out  3        M-cycle index
//   fetch        out  1        this M-cycle fetches the next opcode
//   pc_inc       out  1        advance PC on this fetch
//   int_active   out  1        dispatching an interrupt
//   irq_ack      out  NUM_IRQ  one-hot acknowledge pulse
//   int_vector   out  8        restart address of the acked source
module sm83_sequencer
  import sm83_pkg::*;
#(
  parameter int NUM_IRQ    = 5,
  parameter int DISPATCH_M = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ce,
  input  logic [7:0]         data_in,
  input  logic               mcyc_last,
  input  logic               dec_halt,
  input  logic               dec_stop,
  input  logic               dec_prefix,
  input  logic               ime,
  input  logic [NUM_IRQ-1:0] irq_pending,
  input  logic               wake,
  output logic [7:0]         opcode,
  output logic               bank_cb,
  output logic               in_halt,
  output logic               in_alu,
  output logic [1:0]         t_cycle,
  output logic [2:0]         m_cycle,
  output logic               fetch,
  output logic               pc_inc,
  output logic               int_active,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic [7:0]         int_vector
);

  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam logic [2:0] SEL_M  = 3'd2;
  localparam logic [2:0] LAST_M = 3'(DISPATCH_M - 1);

  seq_state_e         state_q, state_d;
  logic [1:0]         t_q, t_d;
  logic [2:0]         m_q, m_d;
  logic [7:0]         opcode_q, opcode_d;
  logic               bank_cb_q, bank_cb_d;
  logic [7:0]         int_vector_q, int_vector_d;
  logic [NUM_IRQ-1:0] ack_sel_q, ack_sel_d;
  // Set when returning to RUN from HALT/STOP/INT: the next M-cycle must
  // fetch, and the stale opcode's halt/stop strobes no longer apply.
  logic               force_fetch_q, force_fetch_d;
`ifdef SM83_HALT_BUG_EN
  logic               halt_bug_q, halt_bug_d;
`endif

  logic [NUM_IRQ-1:0] prio_onehot;
  logic [IDX_W-1:0]   prio_idx;
  logic               prio_valid;

  logic m_end, irq_any, fetch_now, halt_eff, stop_eff, load_now;

  sm83_irq_prio #(
    .NUM_IRQ (NUM_IRQ),
    .IDX_W   (IDX_W)
  ) u_irq_prio (
    .req_i    (irq_pending),
    .onehot_o (prio_onehot),
    .idx_o    (prio_idx),
    .valid_o  (prio_valid)
  );

  assign m_end     = ce && (t_q == 2'd3);
  assign irq_any   = |irq_pending;
  assign fetch_now = (state_q == ST_RUN) && (mcyc_last || force_fetch_q);
  assign halt_eff  = dec_halt && !force_fetch_q;
  assign stop_eff  = dec_stop && !force_fetch_q;

  always_comb begin
    state_d       = state_q;
    t_d           = t_q;
    m_d           = m_q;
    opcode_d      = opcode_q;
    bank_cb_d     = bank_cb_q;
    int_vector_d  = int_vector_q;
    ack_sel_d     = ack_sel_q;
    force_fetch_d = force_fetch_q;
`ifdef SM83_HALT_BUG_EN
    halt_bug_d    = halt_bug_q;
`endif
    load_now      = 1'b0;
    if (ce) begin
      t_d = t_q + 2'd1;
      if (t_q == 2'd3) begin
        m_d = m_q + 3'd1;
        case (state_q)
          ST_RUN: begin
            if (fetch_now) begin
              force_fetch_d = 1'b0;
`ifdef SM83_HALT_BUG_EN
              halt_bug_d    = 1'b0;
`endif
              // A pending interrupt overrides HALT; a CB prefix is never
              // split from its second byte.
              if (halt_eff && !irq_any) begin
                state_d = ST_HALT;
                m_d     = 3'd0;
              end else if (stop_eff) begin
                state_d = ST_STOP;
                m_d     = 3'd0;
              end else if (ime && irq_any && !dec_prefix) begin
                state_d = ST_INT;
                m_d     = 3'd0;
              end else begin
                load_now  = 1'b1;
                opcode_d  = data_in;
                bank_cb_d = dec_prefix;
                m_d       = 3'd0;
              end
            end
          end
          ST_HALT: begin
            if (irq_any) begin
              m_d = 3'd0;
              if (ime) begin
                state_d = ST_INT;
              end else begin
                state_d       = ST_RUN;
                force_fetch_d = 1'b1;
`ifdef SM83_HALT_BUG_EN
                halt_bug_d    = 1'b1;
`endif
              end
            end
          end
          ST_STOP: begin
            if (wake) begin
              state_d       = ST_RUN;
              m_d           = 3'd0;
              force_fetch_d = 1'b1;
            end
          end
          ST_INT: begin
            // The winning source is frozen here so later IF changes cannot
            // retarget a dispatch already in flight.
            if (m_q == SEL_M) begin
              ack_sel_d    = prio_onehot;
              int_vector_d = prio_valid ? irq_vector(WORD_SIZE'(prio_idx)) : 8'h00;
            end
            if (m_q == LAST_M) begin
              state_d       = ST_RUN;
              m_d           = 3'd0;
              force_fetch_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_RUN;
      t_q           <= 2'd0;
      m_q           <= 3'd0;
      opcode_q      <= 8'h00;
      bank_cb_q     <= 1'b0;
      int_vector_q  <= 8'h00;
      ack_sel_q     <= '0;
      force_fetch_q <= 1'b0;
`ifdef SM83_HALT_BUG_EN
      halt_bug_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      t_q           <= t_d;
      m_q           <= m_d;
      opcode_q      <= opcode_d;
      bank_cb_q     <= bank_cb_d;
      int_vector_q  <= int_vector_d;
      ack_sel_q     <= ack_sel_d;
      force_fetch_q <= force_fetch_d;
`ifdef SM83_HALT_BUG_EN
      halt_bug_q    <= halt_bug_d;
`endif
    end
  end

  // PC advances only when a byte is actually consumed into the opcode
  // register; a fetch that diverts to HALT/STOP/INT leaves it for refetch.
`ifdef SM83_HALT_BUG_EN
  assign pc_inc = load_now && !halt_bug_q && !(halt_eff && irq_any);
`else
  assign pc_inc = load_now;
`endif

  assign irq_ack    = ((state_q == ST_INT) && (m_q == LAST_M) && m_end) ? ack_sel_q : '0;
  assign opcode     = opcode_q;
  assign bank_cb    = bank_cb_q;
  assign in_halt    = (state_q == ST_HALT);
  assign int_active = (state_q == ST_INT);
  assign t_cycle    = t_q;
  assign m_cycle    = m_q;
  assign fetch      = fetch_now;
  assign int_vector = int_vector_q;
  assign in_alu     = !bank_cb_q && ((opcode_q[7:6] == 2'b10) ||
                                     ((opcode_q[7:6] == 2'b11) && (opcode_q[2:0] == 3'b110)));

endmodule
